// File: rtl/des_pkg.sv
// Shared types, widths and slice helpers for the DES S-box substitution sequencer.
package des_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int NUM_SBOX   = 8;
  localparam int DIN_W      = NUM_SBOX * SBOX_IN_W;
  localparam int DOUT_W     = NUM_SBOX * SBOX_OUT_W;

  // Box 0 (S1) sits in the most significant chunk of the expanded word.
  function automatic logic [SBOX_IN_W-1:0] chunk_of(input logic [DIN_W-1:0] d,
                                                    input logic [2:0] box);
    return d[DIN_W-1 - SBOX_IN_W*int'(box) -: SBOX_IN_W];
  endfunction

  function automatic logic [DOUT_W-1:0] put_nibble(input logic [DOUT_W-1:0] d,
                                                   input logic [2:0] box,
                                                   input logic [SBOX_OUT_W-1:0] v);
    logic [DOUT_W-1:0] r;
    r = d;
    r[DOUT_W-1 - SBOX_OUT_W*int'(box) -: SBOX_OUT_W] = v;
    return r;
  endfunction
endpackage

// File: rtl/sbox_subst_seq_if.sv
// Upstream word / downstream result handshakes of the S-box sequencer.
interface sbox_subst_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/sbox_bank.sv
// One shared DES S-box: eight table lookups muxed by a 3-bit box select.
module sbox_bank
  import des_pkg::*;
(
  input  logic [2:0]            sel,
  input  logic [SBOX_IN_W-1:0]  din,
  output logic [SBOX_OUT_W-1:0] dout
);
  // Each table is 64 nibbles row-major (row*16+col), entry 0 in the top nibble.
  localparam logic [255:0] TBL [NUM_SBOX] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  logic [5:0]                           addr;
  logic [NUM_SBOX-1:0][SBOX_OUT_W-1:0] vals;

  // row = {b5,b0}, column = b4..b1
  assign addr = {din[5], din[0], din[4:1]};

  for (genvar b = 0; b < NUM_SBOX; b++) begin : g_box
    assign vals[b] = TBL[b][8'd255 - {addr, 2'b00} -: SBOX_OUT_W];
  end

  assign dout = vals[sel];
endmodule

// File: rtl/sbox_subst_seq.sv
// Iterative DES S-box sequencer: LANES boxes per cycle over a shared bank.
// Optional completed-word counter enabled by SBOX_SEQ_CNT_EN.
module sbox_subst_seq
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sbox_subst_seq_if.slave  bus,
  output logic             busy
`ifdef SBOX_SEQ_CNT_EN
  ,
  output logic [15:0]      word_cnt
`endif
);
  localparam int         STEPS    = NUM_SBOX / LANES;
  localparam logic [2:0] LAST_IDX = 3'((STEPS - 1) * LANES);
  localparam logic [2:0] IDX_INC  = 3'(LANES);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("sbox_subst_seq: LANES must be 1, 2, 4 or 8");
  end

  state_t                               state;
  logic [2:0]                           idx;
  logic [DIN_W-1:0]                     in_reg;
  logic                                 fin;
  logic                                 take;
  logic [LANES-1:0][2:0]                lane_sel;
  logic [LANES-1:0][SBOX_OUT_W-1:0]     nib;
  logic [DOUT_W-1:0]                    od_nxt;

  assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
  assign take         = bus.in_valid && bus.in_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_sel[l] = idx + 3'(l);
    sbox_bank u_bank (
      .sel  (lane_sel[l]),
      .din  (chunk_of(in_reg, lane_sel[l])),
      .dout (nib[l])
    );
  end

  always_comb begin
    od_nxt = bus.out_data;
    for (int l = 0; l < LANES; l++) od_nxt = put_nibble(od_nxt, lane_sel[l], nib[l]);
  end

  // fin marks that the last lookup has landed; the following cycle publishes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      in_reg        <= '0;
      fin           <= 1'b0;
      busy          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (!fin) begin
            bus.out_data <= od_nxt;
            if (idx == LAST_IDX) fin <= 1'b1;
            else                 idx <= idx + IDX_INC;
          end else begin
            fin           <= 1'b0;
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (take) begin
        in_reg <= bus.in_data;
        idx    <= '0;
        fin    <= 1'b0;
        busy   <= 1'b1;
        state  <= RUN;
      end
    end
  end

`ifdef SBOX_SEQ_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               word_cnt <= '0;
    else if (bus.out_valid && bus.out_ready) word_cnt <= word_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sbox_subst_seq.sv
// Directed bench for sbox_subst_seq: LANES=1 and LANES=8 instances side by side.
module tb_sbox_subst_seq;
  localparam logic [47:0] GARB = 48'hDEAD_BEEF_CAFE;

  logic clk = 1'b0;
  logic rst_n;
  logic busy_a, busy_b;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sbox_subst_seq_if ia ();
  sbox_subst_seq_if ib ();

`ifdef SBOX_SEQ_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  sbox_subst_seq #(.LANES(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia),
    .busy  (busy_a)
`ifdef SBOX_SEQ_CNT_EN
    ,
    .word_cnt (cnt_a)
`endif
  );

  sbox_subst_seq #(.LANES(8)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib),
    .busy  (busy_b)
`ifdef SBOX_SEQ_CNT_EN
    ,
    .word_cnt (cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [47:0] d, input logic ordy);
    if (w == 0) begin ia.in_valid = v; ia.in_data = d; ia.out_ready = ordy; end
    else        begin ib.in_valid = v; ib.in_data = d; ib.out_ready = ordy; end
  endtask

  function automatic logic ov(input int w);
    return (w == 0) ? ia.out_valid : ib.out_valid;
  endfunction

  function automatic logic [31:0] od(input int w);
    return (w == 0) ? ia.out_data : ib.out_data;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Counts edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(input int w, input int exp_lat, input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!ov(w) && n < 40);
    chk({tag, "_lat"}, 48'(n), 48'(exp_lat));
  endtask

  task automatic run_word(input int w, input logic [47:0] d, input logic [31:0] exp,
                          input int lat, input string tag);
    drive(w, 1'b1, d, 1'b1);
    tick();
    drive(w, 1'b0, GARB, 1'b1);
    wait_out(w, lat, tag);
    chk({tag, "_data"}, 48'(od(w)), 48'(exp));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        seen;
    rst_n = 1'b0;
    drive(0, 1'b0, '0, 1'b1);
    drive(1, 1'b0, '0, 1'b1);
    #12;
    chk("rst_ov_a",   48'(ia.out_valid), 48'd0);
    chk("rst_busy_a", 48'(busy_a),       48'd0);
    chk("rst_ir_a",   48'(ia.in_ready),  48'd1);
    chk("rst_od_a",   48'(ia.out_data),  48'd0);
    chk("rst_ov_b",   48'(ib.out_valid), 48'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // LANES=1, all-zero word
    drive(0, 1'b1, 48'h0, 1'b1);
    tick();
    drive(0, 1'b0, GARB, 1'b1);
    chk("a0_busy", 48'(busy_a),      48'd1);
    chk("a0_ir",   48'(ia.in_ready), 48'd0);
    wait_out(0, 9, "a0");
    chk("a0_data", 48'(ia.out_data), 48'hEFA72C4D);
    tick();
    chk("a0_ov_clr", 48'(ia.out_valid), 48'd0);
    chk("a0_idle",   48'(busy_a),       48'd0);

    // LANES=1, all-ones word held under backpressure
    drive(0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0);
    tick();
    drive(0, 1'b0, GARB, 1'b0);
    wait_out(0, 9, "a1");
    chk("a1_data", 48'(ia.out_data), 48'hD9CE3DCB);
    held = ia.out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", 48'(ia.out_data),  48'(held));
      chk("bp_ir",   48'(ia.in_ready),  48'd0);
      chk("bp_ov",   48'(ia.out_valid), 48'd1);
    end
    drive(0, 1'b1, 48'h001083105187, 1'b1);
    #1;
    chk("bp_ir_pass", 48'(ia.in_ready), 48'd1);
    tick();
    drive(0, 1'b0, GARB, 1'b1);
    chk("bp_ov_drop", 48'(ia.out_valid), 48'd0);
    chk("bp_busy",    48'(busy_a),       48'd1);
    wait_out(0, 9, "bp_next");
    chk("bp_next_data", 48'(ia.out_data), 48'hE30844E8);
    tick();

    // LANES=8, back-to-back words
    drive(1, 1'b1, 48'h0, 1'b1);
    tick();
    drive(1, 1'b0, GARB, 1'b1);
    wait_out(1, 2, "b0");
    chk("b0_data", 48'(ib.out_data), 48'hEFA72C4D);
    drive(1, 1'b1, 48'h820820820820, 1'b1);
    tick();
    drive(1, 1'b0, GARB, 1'b1);
    wait_out(1, 2, "b1");
    chk("b1_data", 48'(ib.out_data), 48'h40DA4917);
    tick();
    chk("b1_idle", 48'(busy_b), 48'd0);

    // Reset in the middle of a LANES=1 word
    drive(0, 1'b1, 48'h041041041041, 1'b1);
    tick();
    drive(0, 1'b0, GARB, 1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("ab_ov",   48'(ia.out_valid), 48'd0);
    chk("ab_busy", 48'(busy_a),       48'd0);
    chk("ab_ir",   48'(ia.in_ready),  48'd1);
    chk("ab_od",   48'(ia.out_data),  48'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | ia.out_valid;
    end
    chk("ab_no_out", 48'(seen), 48'd0);
    run_word(0, 48'h041041041041, 32'h03DDEAD1, 9, "a2");

`ifdef SBOX_SEQ_CNT_EN
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("cnt_rst", 48'(cnt_a), 48'd0);
    run_word(0, 48'h0,             32'hEFA72C4D, 9, "c0");
    run_word(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 9, "c1");
    run_word(0, 48'h001083105187,  32'hE30844E8, 9, "c2");
    chk("cnt_three", 48'(cnt_a), 48'd3);
    force u_a.word_cnt = 16'hFFFF;
    @(negedge clk) release u_a.word_cnt;
    run_word(0, 48'h0, 32'hEFA72C4D, 9, "c3");
    chk("cnt_wrap", 48'(cnt_a), 48'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
